// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback selects,
// forwarding selects and sequencer states.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'b00,
        WSEL_DRAM = 2'b01,
        WSEL_PC4  = 2'b10
    } wsel_e;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_MEM_ALU = 2'b01,
        FWD_WB      = 2'b10,
        FWD_MEM_PC4 = 2'b11
    } fwd_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-tagged pipeline fields into the hazard controller and its stall/flush/forward
// controls back out. PIPE_PERF_CNT_EN adds the performance counter outputs.
interface pipe_hazard_ctrl_if;

    logic [4:0] ID_rs1, ID_rs2;
    logic       ID_re1, ID_re2;
    logic [4:0] EX_rs1, EX_rs2;
    logic [4:0] EX_wR;
    logic       EX_rf_we;
    logic [1:0] EX_rf_wsel;
    logic       EX_br_taken;
    logic [4:0] MEM_wR;
    logic       MEM_rf_we;
    logic [1:0] MEM_rf_wsel;
    logic       MEM_dram_req;
    logic       dram_ready;
    logic [4:0] WB_wR;
    logic       WB_rf_we;

    logic       pc_stall;
    logic       IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic       IF_ID_flush, ID_EX_flush, MEM_WB_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       err_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    // Pipeline side: drives the stage fields, consumes the controls.
    modport master (
        output ID_rs1, ID_rs2, ID_re1, ID_re2, EX_rs1, EX_rs2, EX_wR, EX_rf_we,
               EX_rf_wsel, EX_br_taken, MEM_wR, MEM_rf_we, MEM_rf_wsel,
               MEM_dram_req, dram_ready, WB_wR, WB_rf_we,
        input  pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush,
               ID_EX_flush, MEM_WB_flush, fwd_a, fwd_b, err_timeout
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    // Hazard controller side.
    modport slave (
        input  ID_rs1, ID_rs2, ID_re1, ID_re2, EX_rs1, EX_rs2, EX_wR, EX_rf_we,
               EX_rf_wsel, EX_br_taken, MEM_wR, MEM_rf_we, MEM_rf_wsel,
               MEM_dram_req, dram_ready, WB_wR, WB_rf_we,
        output pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush,
               ID_EX_flush, MEM_WB_flush, fwd_a, fwd_b, err_timeout
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX source register; MEM beats WB, x0 never forwards.
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_wr,
    input  logic       mem_rf_we,
    input  logic [1:0] mem_rf_wsel,
    input  logic [4:0] wb_wr,
    input  logic       wb_rf_we,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (rs != 5'd0) begin
            if (mem_rf_we && (mem_wr == rs)) begin
                fwd = (mem_rf_wsel == WSEL_PC4) ? FWD_MEM_PC4 : FWD_MEM_ALU;
            end else if (wb_rf_we && (wb_wr == rs)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: DRAM-wait freeze with timeout, branch redirect, load-use stall
// and EX forwarding. Define PIPE_PERF_CNT_EN to add stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_timeout_q;

    logic mem_busy;
    logic freeze;
    logic load_use;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    assign mem_busy = hz.MEM_dram_req & ~hz.dram_ready;
    // Once waiting, only dram_ready matters; the request itself is held frozen in MEM.
    assign freeze   = (state == ST_RUN) ? mem_busy : ~hz.dram_ready;
    assign load_use = hz.EX_rf_we & (hz.EX_rf_wsel == WSEL_DRAM) & (hz.EX_wR != 5'd0)
                    & ((hz.ID_re1 & (hz.ID_rs1 == hz.EX_wR))
                     | (hz.ID_re2 & (hz.ID_rs2 == hz.EX_wR)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (hz.EX_br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    // Timeout flags on the wait cycle where the count reaches MAX_WAIT; the
    // access keeps waiting, the flag is only a sticky error report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_RUN;
            wait_cnt      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                        err_timeout_q <= 1'b1;
                    end
                    if (hz.dram_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    pipe_hazard_ctrl_fwd_sel u_fwd_a (
        .rs          (hz.EX_rs1),
        .mem_wr      (hz.MEM_wR),
        .mem_rf_we   (hz.MEM_rf_we),
        .mem_rf_wsel (hz.MEM_rf_wsel),
        .wb_wr       (hz.WB_wR),
        .wb_rf_we    (hz.WB_rf_we),
        .fwd         (fwd_a_raw)
    );

    pipe_hazard_ctrl_fwd_sel u_fwd_b (
        .rs          (hz.EX_rs2),
        .mem_wr      (hz.MEM_wR),
        .mem_rf_we   (hz.MEM_rf_we),
        .mem_rf_wsel (hz.MEM_rf_wsel),
        .wb_wr       (hz.WB_wR),
        .wb_rf_we    (hz.WB_rf_we),
        .fwd         (fwd_b_raw)
    );

    assign hz.pc_stall     = pc_stall;
    assign hz.IF_ID_stall  = if_id_stall;
    assign hz.ID_EX_stall  = id_ex_stall;
    assign hz.EX_MEM_stall = ex_mem_stall;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.ID_EX_flush  = id_ex_flush;
    assign hz.MEM_WB_flush = mem_wb_flush;
    assign hz.fwd_a        = rst ? fwd_a_raw : FWD_RF;
    assign hz.fwd_b        = rst ? fwd_b_raw : FWD_RF;
    assign hz.err_timeout  = err_timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (if_id_flush | id_ex_flush) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`endif

endmodule
